// File: rtl/hft_pkg.sv
// Shared definitions for the order transmit path: frame constants,
// side encoding, tx FSM states and the frame byte selector.
package hft_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 12;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK,
        ST_DONE
    } tx_state_e;

    // Byte idx of a frame; byte 11 is the XOR of bytes 1..10.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  addr,
        input logic        side,
        input logic [31:0] price,
        input logic [31:0] vol
    );
        logic [7:0] side_b;
        logic [7:0] csum;
        side_b = (side == SIDE_SELL) ? 8'h01 : 8'h00;
        csum = addr ^ side_b
             ^ price[31:24] ^ price[23:16] ^ price[15:8] ^ price[7:0]
             ^ vol[31:24] ^ vol[23:16] ^ vol[15:8] ^ vol[7:0];
        case (idx)
            4'd0:    frame_byte = FRAME_HDR;
            4'd1:    frame_byte = addr;
            4'd2:    frame_byte = side_b;
            4'd3:    frame_byte = price[31:24];
            4'd4:    frame_byte = price[23:16];
            4'd5:    frame_byte = price[15:8];
            4'd6:    frame_byte = price[7:0];
            4'd7:    frame_byte = vol[31:24];
            4'd8:    frame_byte = vol[23:16];
            4'd9:    frame_byte = vol[15:8];
            4'd10:   frame_byte = vol[7:0];
            4'd11:   frame_byte = csum;
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr.
// Ports: req, ptr in; gnt_idx, gnt_valid out.
module rr_arbiter #(
    parameter int NUM_SYS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SYS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    int j;

    // Walk downward in search distance so the closest request wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = NUM_SYS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_SYS) begin
                j = j - NUM_SYS;
            end
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tx_mux.sv
// Buffers one order record per system, round-robin selects one and
// serializes it as a 12-byte frame over a start/busy UART handshake.
// Ports: sys_* record inputs and sys_busy; tx_byte/tx_start/tx_busy to
// the UART; frame_done pulse; saturating drop_cnt.
module tx_mux
    import hft_pkg::*;
#(
    parameter int NUM_SYS = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SYS*32-1:0]   sys_price,
    input  logic [NUM_SYS*32-1:0]   sys_vol,
    input  logic [NUM_SYS-1:0]      sys_side,
    input  logic [NUM_SYS-1:0]      sys_dv,
    output logic [NUM_SYS-1:0]      sys_busy,
    output logic [7:0]              tx_byte,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic                    frame_done,
    output logic [15:0]             drop_cnt
);

    localparam int IDX_W = (NUM_SYS > 1) ? $clog2(NUM_SYS) : 1;

    logic [31:0]        price_q [NUM_SYS];
    logic [31:0]        vol_q   [NUM_SYS];
    logic [NUM_SYS-1:0] side_q;
    logic [NUM_SYS-1:0] hold_valid_q;

    tx_state_e          state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [3:0]         idx_q;
    logic [7:0]         tx_byte_q;
    logic [7:0]         fr_addr_q;
    logic               fr_side_q;
    logic [31:0]        fr_price_q;
    logic [31:0]        fr_vol_q;
    logic [15:0]        drop_q;
    logic [15:0]        drop_d;

    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               grant;
    logic [NUM_SYS-1:0] clr;
    logic [NUM_SYS-1:0] drop;
    logic [4:0]         drop_inc;
    logic [16:0]        drop_sum;
    logic               last_byte;

    rr_arbiter #(
        .NUM_SYS (NUM_SYS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (hold_valid_q),
        .ptr       (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign grant     = (state_q == ST_IDLE) && gnt_valid;
    assign last_byte = (idx_q == 4'(FRAME_LEN - 1));

    // A slot being granted this cycle may accept a new record at once.
    always_comb begin
        clr      = '0;
        drop     = '0;
        drop_inc = '0;
        for (int i = 0; i < NUM_SYS; i++) begin
            clr[i]   = grant && (gnt_idx == IDX_W'(i));
            drop[i]  = sys_dv[i] && hold_valid_q[i] && !clr[i];
            drop_inc = drop_inc + 5'(drop[i]);
        end
        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= '0;
            side_q       <= '0;
            drop_q       <= '0;
            for (int i = 0; i < NUM_SYS; i++) begin
                price_q[i] <= '0;
                vol_q[i]   <= '0;
            end
        end else begin
            drop_q <= drop_d;
            for (int i = 0; i < NUM_SYS; i++) begin
                if (sys_dv[i] && (!hold_valid_q[i] || clr[i])) begin
                    price_q[i]      <= sys_price[i*32 +: 32];
                    vol_q[i]        <= sys_vol[i*32 +: 32];
                    side_q[i]       <= sys_side[i];
                    hold_valid_q[i] <= 1'b1;
                end else if (clr[i]) begin
                    hold_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            tx_byte_q  <= 8'h00;
            fr_addr_q  <= 8'h00;
            fr_side_q  <= SIDE_BUY;
            fr_price_q <= '0;
            fr_vol_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        fr_addr_q  <= 8'(gnt_idx);
                        fr_side_q  <= side_q[gnt_idx];
                        fr_price_q <= price_q[gnt_idx];
                        fr_vol_q   <= vol_q[gnt_idx];
                        if (gnt_idx == IDX_W'(NUM_SYS - 1)) begin
                            rr_ptr_q <= '0;
                        end else begin
                            rr_ptr_q <= gnt_idx + IDX_W'(1);
                        end
                        idx_q     <= 4'd0;
                        tx_byte_q <= FRAME_HDR;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    if (tx_busy) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!tx_busy) begin
                        if (last_byte) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_byte_q <= frame_byte(idx_q + 4'd1, fr_addr_q,
                                                    fr_side_q, fr_price_q,
                                                    fr_vol_q);
                            state_q   <= ST_SEND;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sys_busy   = hold_valid_q;
    assign tx_byte    = tx_byte_q;
    assign tx_start   = (state_q == ST_SEND);
    assign frame_done = (state_q == ST_DONE) && !tx_busy && last_byte;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_tx_mux.sv
// Scoreboard bench for tx_mux: stimulus queues expected frame bytes,
// a monitor pops them on each tx_start, a UART model answers busy.
module tb_tx_mux;

    logic        clk;
    logic        reset_n;
    logic [63:0] sys_price;
    logic [63:0] sys_vol;
    logic [1:0]  sys_side;
    logic [1:0]  sys_dv;
    logic [1:0]  sys_busy;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy;
    logic        frame_done;
    logic [15:0] drop_cnt;

    int total;
    int bad;
    int done_cnt;
    int byte_in_frame;
    int busy_len;
    logic [7:0] exp_q [$];

    tx_mux #(.NUM_SYS(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sys_price  (sys_price),
        .sys_vol    (sys_vol),
        .sys_side   (sys_side),
        .sys_dv     (sys_dv),
        .sys_busy   (sys_busy),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] a, input logic s,
                                       input logic [31:0] p,
                                       input logic [31:0] v);
        logic [7:0] b [12];
        logic [7:0] x;
        b[0] = 8'hA5; b[1] = a; b[2] = {7'd0, s};
        b[3] = p[31:24]; b[4] = p[23:16]; b[5] = p[15:8]; b[6] = p[7:0];
        b[7] = v[31:24]; b[8] = v[23:16]; b[9] = v[15:8]; b[10] = v[7:0];
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ b[i];
        b[11] = x;
        for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] dv, input logic [1:0] side,
                         input logic [63:0] p, input logic [63:0] v);
        sys_dv    = dv;
        sys_side  = side;
        sys_price = p;
        sys_vol   = v;
        step();
        sys_dv = 2'b00;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_count", done_cnt, target);
        step();
    endtask

    task automatic wait_bytes(input int k);
        int n;
        n = 0;
        while (byte_in_frame < k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("wait_bytes_timeout", 1, 0);
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_sys_busy", sys_busy, 2'b00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 16'h0000);
        step();
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    // Scoreboard monitor: each tx_start consumes one expected byte.
    initial begin
        done_cnt      = 0;
        byte_in_frame = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                byte_in_frame = 0;
            end else begin
                if (tx_start) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_byte: got %h want none",
                                 tx_byte);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (tx_byte !== e) begin
                            bad++;
                            $display("FAIL byte%0d: got %h want %h",
                                     byte_in_frame, tx_byte, e);
                        end
                    end
                    byte_in_frame++;
                end
                if (frame_done) begin
                    total++;
                    if (byte_in_frame != 12) begin
                        bad++;
                        $display("FAIL done_pos: got %0d want 12",
                                 byte_in_frame);
                    end
                    byte_in_frame = 0;
                    done_cnt++;
                end
            end
        end
    end

    // UART model: busy rises the cycle after tx_start, lasts busy_len.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && reset_n) begin
                logic [7:0] held;
                bit unstable;
                bit extra;
                held     = tx_byte;
                unstable = 1'b0;
                extra    = 1'b0;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) begin
                    @(negedge clk);
                    if (reset_n && tx_byte !== held) unstable = 1'b1;
                    if (tx_start) extra = 1'b1;
                    @(posedge clk);
                end
                #1 tx_busy = 1'b0;
                if (reset_n) begin
                    chk("byte_stable", {31'd0, unstable}, 0);
                    chk("no_start_while_busy", {31'd0, extra}, 0);
                end
            end
        end
    end

    initial begin
        logic [7:0] t1 [12];
        int cyc;
        total     = 0;
        bad       = 0;
        busy_len  = 3;
        sys_dv    = 2'b00;
        sys_side  = 2'b00;
        sys_price = '0;
        sys_vol   = '0;
        t1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12,
               8'h34, 8'h00, 8'h00, 8'h00, 8'h10, 8'h36};

        do_reset();

        // single buy on sys0 with hand-computed frame and latency
        for (int i = 0; i < 12; i++) exp_q.push_back(t1[i]);
        issue(2'b01, 2'b00, {32'd0, 32'h00001234}, {32'd0, 32'h00000010});
        cyc = 1;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) break;
            cyc++;
        end
        chk("first_start_latency", cyc, 2);
        step();
        wait_done(1);

        // simultaneous sys0 / sys1 from rr_ptr 0
        do_reset();
        push_frame(8'h00, 1'b0, 32'h11223344, 32'h00000005);
        push_frame(8'h01, 1'b1, 32'hDEADBEEF, 32'h00000100);
        issue(2'b11, 2'b10, {32'hDEADBEEF, 32'h11223344},
              {32'h00000100, 32'h00000005});
        wait_done(3);

        // fairness: reload both during a sys0 frame
        push_frame(8'h00, 1'b0, 32'h0000AAAA, 32'h00000001);
        issue(2'b01, 2'b00, {32'd0, 32'h0000AAAA}, {32'd0, 32'h00000001});
        wait_bytes(2);
        push_frame(8'h01, 1'b0, 32'h0000CCCC, 32'h00000003);
        push_frame(8'h00, 1'b1, 32'h0000BBBB, 32'h00000002);
        issue(2'b11, 2'b01, {32'h0000CCCC, 32'h0000BBBB},
              {32'h00000003, 32'h00000002});
        wait_done(6);

        // drops: three sys0 strobes while engine busy
        push_frame(8'h01, 1'b1, 32'h01020304, 32'h05060708);
        issue(2'b10, 2'b10, {32'h01020304, 32'd0}, {32'h05060708, 32'd0});
        wait_bytes(1);
        push_frame(8'h00, 1'b0, 32'h00000E0E, 32'h0000000E);
        for (int s = 0; s < 3; s++) begin
            issue(2'b01, 2'b00, {32'd0, 32'h00000E0E + 32'(s)},
                  {32'd0, 32'h0000000E});
            @(negedge clk);
            chk("busy0_held", sys_busy[0], 1'b1);
            step();
        end
        chk("drop_cnt_2", drop_cnt, 16'd2);
        wait_done(8);
        chk("drop_cnt_after", drop_cnt, 16'd2);

        // stall: tx_busy held for 100 cycles on the header
        busy_len = 100;
        push_frame(8'h01, 1'b0, 32'hCAFEF00D, 32'h12345678);
        issue(2'b10, 2'b00, {32'hCAFEF00D, 32'd0}, {32'h12345678, 32'd0});
        cyc = 0;
        while (!tx_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #2 busy_len = 3;
        cyc = 0;
        repeat (500) begin
            @(negedge clk);
            cyc++;
            if (tx_start) break;
        end
        chk("stall_gap_gt100", {31'd0, (cyc > 100)}, 1);
        step();
        wait_done(9);

        // reset at byte 5 with a held sys1 record
        push_frame(8'h00, 1'b1, 32'h55555555, 32'h66666666);
        issue(2'b01, 2'b01, {32'd0, 32'h55555555}, {32'd0, 32'h66666666});
        wait_bytes(2);
        issue(2'b10, 2'b00, {32'h77777777, 32'd0}, {32'h88888888, 32'd0});
        wait_bytes(5);
        do_reset();
        repeat (10) step();
        push_frame(8'h01, 1'b0, 32'h0BADCAFE, 32'h00000042);
        issue(2'b10, 2'b00, {32'h0BADCAFE, 32'd0}, {32'h00000042, 32'd0});
        wait_done(10);
        repeat (80) step();
        chk("queue_drained", exp_q.size(), 0);
        chk("final_done_count", done_cnt, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
